// File: rtl/rr_arbiter_4x_if.sv
// Request/grant bundle for the four-way round-robin arbiter.
// master drives requests and observes grants; slave is the arbiter side.
interface rr_arbiter_4x_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, preempt
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, preempt
  );
endinterface

// File: rtl/rr_arbiter_4x.sv
// Four-requester round-robin arbiter with registered grant and hold-until-release.
// Optional hold timeout with preemption is enabled by defining HOLD_TIMEOUT_EN.
module rr_arbiter_4x #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4x_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_params
    $error("rr_arbiter_4x: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic [1:0] last_idx_q, last_idx_d;
  logic       preempt_q, preempt_d;
  logic [1:0] winner;

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(MAX_HOLD - 1)) && ((bus.req & ~gnt_q) != '0);
`endif

  // Scan from lowest priority (last) up to highest (last-1); later hits overwrite.
  always_comb begin
    winner = last_idx_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (bus.req[last_idx_q + 2'(k)]) begin
        winner = last_idx_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    preempt_d  = 1'b0;
`ifdef HOLD_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          state_d    = BUSY;
          gnt_d      = 4'b0001 << winner;
          gnt_idx_d  = winner;
          last_idx_d = winner;
`ifdef HOLD_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
`ifdef HOLD_TIMEOUT_EN
        if (timeout) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          preempt_d = 1'b1;
        end else if (bus.req[gnt_idx_q]) begin
          if (cnt_q != CNT_W'(MAX_HOLD)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
        end
`else
        if (!bus.req[gnt_idx_q]) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      last_idx_q <= '0;
      preempt_q  <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      preempt_q  <= preempt_d;
`ifdef HOLD_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = (state_q == BUSY);
`ifdef HOLD_TIMEOUT_EN
  assign bus.preempt   = preempt_q;
`else
  assign bus.preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4x.sv
// Scoreboard bench for rr_arbiter_4x: directed scenarios plus random requests,
// predicted by an owner/pointer model and checked by an independent monitor.
module tb_rr_arbiter_4x;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic clk;
  logic rst_n;

  rr_arbiter_4x_if bus ();

  rr_arbiter_4x #(
    .MAX_HOLD(TB_MAX_HOLD),
    .CNT_W   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: owner (-1 = none), last winner, cycles held.
  int m_owner = -1;
  int m_last  = 0;
  int m_hold  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_step(input logic [3:0] r);
    exp_t e;
    logic pre;
    pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last - k + 8) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_last  = c;
          m_hold  = 0;
        end
      end
    end else begin
`ifdef HOLD_TIMEOUT_EN
      if (m_hold == TB_MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_owner = -1;
        pre     = 1'b1;
      end else
`endif
      if (r[m_owner]) begin
        if (m_hold < TB_MAX_HOLD) m_hold++;
      end else begin
        m_owner = -1;
      end
    end
    e.gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.idx   = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.valid = (m_owner >= 0);
    e.pre   = pre;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic [3:0] r);
    bus.req = r;
    model_step(r);
  endtask

  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    drive(r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},   {4'b0, bus.gnt},       8'h00);
    check({tag, "_idx"},   {6'b0, bus.gnt_idx},   8'h00);
    check({tag, "_valid"}, {7'b0, bus.gnt_valid}, 8'h00);
    check({tag, "_pre"},   {7'b0, bus.preempt},   8'h00);
  endtask

  // Monitor: every output cycle consumes one prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",       {4'b0, bus.gnt},       {4'b0, e.gnt});
        check("gnt_idx",   {6'b0, bus.gnt_idx},   {6'b0, e.idx});
        check("gnt_valid", {7'b0, bus.gnt_valid}, {7'b0, e.valid});
        check("preempt",   {7'b0, bus.preempt},   {7'b0, e.pre});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o;
    logic [3:0] r;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    drive(4'b0000);

    // Fixed-priority start, release, then lower agent
    cyc(4'b0101);
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0001);
    cyc(4'b0000);
    cyc(4'b0000);

    // All requesting, each owner holds two cycles
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111);
      o = m_owner;
      cyc(4'b1111);
      cyc(4'b1111 & ~(4'b0001 << o));
    end
    cyc(4'b0000);

    repeat (10) cyc(4'b0000);

    // Owner 1 releases while req[3] rises in the same cycle
    cyc(4'b0010);
    cyc(4'b0010);
    cyc(4'b1000);
    cyc(4'b1000);
    cyc(4'b0000);
    cyc(4'b0000);

    // Asynchronous reset mid-grant
    cyc(4'b0100);
    cyc(4'b0100);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    m_owner = -1;
    m_last  = 0;
    m_hold  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0011);
    cyc(4'b0000);
    cyc(4'b0000);

    // Hold with a competitor waiting, then hold with nobody waiting
    cyc(4'b0000);
    cyc(4'b0100);
    repeat (8) cyc(4'b0101);
    cyc(4'b0000);
    cyc(4'b0000);
    cyc(4'b0100);
    repeat (25) cyc(4'b0100);
    cyc(4'b0000);

    // Random traffic; owner mostly keeps its request up
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r = 4'b0000;
      if (m_owner >= 0 && $urandom_range(0, 99) < 80) r[m_owner] = 1'b1;
      cyc(r);
    end
    cyc(4'b0000);

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
